// File: rtl/radius_pkg.sv
// rtl/radius_pkg.sv - shared types and requester indices for the radius controller
package radius_pkg;
    typedef enum logic {IDLE, RAMP} state_t;

    localparam int NREQ      = 4;
    localparam int REQ_EAT   = 0;
    localparam int REQ_PLUS  = 1;
    localparam int REQ_MINUS = 2;
    localparam int REQ_DECAY = 3;

    typedef enum logic {DIR_GROW, DIR_SHRINK} dir_t;
endpackage

// File: rtl/btn_repeat.sv
// rtl/btn_repeat.sv - button edge detect with auto-repeat while held
module btn_repeat #(
    parameter int REPEAT_CYC = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic inhibit,
    output logic req
);
    localparam int CW = $clog2(REPEAT_CYC + 1);

    logic          btn_q;
    logic [CW-1:0] cnt;
    logic          active;

    // cnt counts held cycles since the last request; it wraps to 1 so repeats land every REPEAT_CYC
    assign active = btn & ~inhibit;
    assign req    = active & (~btn_q | (cnt == CW'(REPEAT_CYC)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
            cnt   <= '0;
        end else begin
            btn_q <= btn;
            if (!active)
                cnt <= '0;
            else if (cnt == CW'(REPEAT_CYC))
                cnt <= CW'(1);
            else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/radius_ctrl.sv
// rtl/radius_ctrl.sv - arbitrates radius change requests and ramps r one unit per tick
module radius_ctrl
    import radius_pkg::*;
#(
    parameter int W          = 6,
    parameter int R_INIT     = 25,
    parameter int R_MIN      = 5,
    parameter int R_MAX      = 55,
    parameter int STEP       = 5,
    parameter int REPEAT_CYC = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         btn_plus,
    input  logic         btn_minus,
    input  logic         eat_evt,
    input  logic         decay_evt,
    output logic [W-1:0] r,
    output logic         busy,
    output logic         at_max,
    output logic         at_min
);
    logic            plus_req, minus_req;
    logic [NREQ-1:0] pending, new_req, grant;
    state_t          state;
    dir_t            gdir;
    logic [W-1:0]    target, tgt_next, r_step;
    logic [W:0]      grow_sum;

    btn_repeat #(.REPEAT_CYC(REPEAT_CYC)) u_plus (
        .clk(clk), .rst_n(rst_n), .btn(btn_plus), .inhibit(btn_minus), .req(plus_req)
    );
    btn_repeat #(.REPEAT_CYC(REPEAT_CYC)) u_minus (
        .clk(clk), .rst_n(rst_n), .btn(btn_minus), .inhibit(btn_plus), .req(minus_req)
    );

    always_comb begin
        new_req            = '0;
        new_req[REQ_EAT]   = eat_evt;
        new_req[REQ_PLUS]  = plus_req;
        new_req[REQ_MINUS] = minus_req;
        new_req[REQ_DECAY] = decay_evt;

        grant = '0;
        if (state == IDLE) begin
            if (pending[REQ_EAT])        grant[REQ_EAT]   = 1'b1;
            else if (pending[REQ_PLUS])  grant[REQ_PLUS]  = 1'b1;
            else if (pending[REQ_MINUS]) grant[REQ_MINUS] = 1'b1;
            else if (pending[REQ_DECAY]) grant[REQ_DECAY] = 1'b1;
        end

        gdir     = (grant[REQ_EAT] | grant[REQ_PLUS]) ? DIR_GROW : DIR_SHRINK;
        // extra bit keeps r+STEP from wrapping before the clamp
        grow_sum = {1'b0, r} + (W+1)'(STEP);
        if (gdir == DIR_GROW)
            tgt_next = (grow_sum > (W+1)'(R_MAX)) ? W'(R_MAX) : grow_sum[W-1:0];
        else
            tgt_next = ({1'b0, r} < (W+1)'(R_MIN + STEP)) ? W'(R_MIN) : r - W'(STEP);

        r_step = (r < target) ? r + 1'b1 : r - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r       <= W'(R_INIT);
            target  <= W'(R_INIT);
            pending <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
        end else begin
            pending <= (pending | new_req) & ~grant;
            case (state)
                IDLE: begin
                    if (|grant) begin
                        target <= tgt_next;
                        if (tgt_next != r) begin
                            state <= RAMP;
                            busy  <= 1'b1;
                        end
                    end
                end
                RAMP: begin
                    if (tick) begin
                        r <= r_step;
                        if (r_step == target) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign at_max = (r == W'(R_MAX));
    assign at_min = (r == W'(R_MIN));
endmodule

// File: tb/tb_radius_ctrl.sv
// tb/tb_radius_ctrl.sv - self-checking bench for radius_ctrl
module tb_radius_ctrl;
    logic       clk, rst_n, tick, btn_plus, btn_minus, eat_evt, decay_evt;
    logic [5:0] r, r2;
    logic       busy, at_max, at_min, busy2, at_max2, at_min2;

    int pass_cnt = 0;
    int total_cnt = 0;

    radius_ctrl dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_plus(btn_plus), .btn_minus(btn_minus),
        .eat_evt(eat_evt), .decay_evt(decay_evt), .r(r), .busy(busy), .at_max(at_max), .at_min(at_min)
    );
    radius_ctrl #(.R_INIT(52)) dut2 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_plus(btn_plus), .btn_minus(btn_minus),
        .eat_evt(eat_evt), .decay_evt(decay_evt), .r(r2), .busy(busy2), .at_max(at_max2), .at_min(at_min2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        tick = 1'b0; btn_plus = 1'b0; btn_minus = 1'b0; eat_evt = 1'b0; decay_evt = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        nxt();
        rst_n = 1'b0;
        nxt();
        rst_n = 1'b1;
    endtask

    // Reference model: radius, target, ramp flag, per-requester pending, button hold run lengths
    int m_r, m_tgt, run_p, run_m;
    bit m_ramp, prev_p, prev_m;
    bit m_pend[4];

    task automatic model_reset();
        m_r = 25; m_tgt = 25; m_ramp = 0; run_p = 0; run_m = 0; prev_p = 0; prev_m = 0;
        foreach (m_pend[i]) m_pend[i] = 0;
    endtask

    task automatic model_step();
        bit act_p, act_m;
        bit nr[4];
        int g;
        act_p = btn_plus && !btn_minus;
        act_m = btn_minus && !btn_plus;
        nr[0] = eat_evt;
        nr[1] = act_p && ((run_p == 0) ? !prev_p : (run_p % 8 == 0));
        nr[2] = act_m && ((run_m == 0) ? !prev_m : (run_m % 8 == 0));
        nr[3] = decay_evt;
        run_p = act_p ? run_p + 1 : 0;
        run_m = act_m ? run_m + 1 : 0;
        prev_p = btn_plus;
        prev_m = btn_minus;
        g = -1;
        if (!m_ramp)
            for (int i = 0; i < 4; i++)
                if (m_pend[i] && g < 0) g = i;
        if (g >= 0) begin
            m_tgt = (g <= 1) ? ((m_r + 5 > 55) ? 55 : m_r + 5) : ((m_r - 5 < 5) ? 5 : m_r - 5);
            if (m_tgt != m_r) m_ramp = 1;
        end else if (m_ramp && tick) begin
            m_r += (m_tgt > m_r) ? 1 : -1;
            if (m_r == m_tgt) m_ramp = 0;
        end
        for (int i = 0; i < 4; i++)
            m_pend[i] = (m_pend[i] || nr[i]) && (i != g);
    endtask

    typedef struct {
        bit tk;
        bit eat;
        int exp_r;
        bit exp_busy;
        int n;
    } vec_t;
    vec_t tv [14];

    initial begin
        int periods, maxr, busy_seen, act, exp;
        bit pb, hit;

        tv = '{
            '{1'b0, 1'b1, 25, 1'b0, 1}, '{1'b1, 1'b0, 25, 1'b0, 1}, '{1'b0, 1'b0, 25, 1'b1, 1},
            '{1'b1, 1'b0, 25, 1'b1, 1}, '{1'b0, 1'b0, 26, 1'b1, 3}, '{1'b1, 1'b0, 26, 1'b1, 1},
            '{1'b0, 1'b0, 27, 1'b1, 3}, '{1'b1, 1'b0, 27, 1'b1, 1}, '{1'b0, 1'b0, 28, 1'b1, 3},
            '{1'b1, 1'b0, 28, 1'b1, 1}, '{1'b0, 1'b0, 29, 1'b1, 3}, '{1'b1, 1'b0, 29, 1'b1, 1},
            '{1'b0, 1'b0, 30, 1'b0, 2}, '{1'b0, 1'b0, 30, 1'b0, 1}
        };

        rst_n = 1'b0;
        clr_in();
        nxt();
        rst_n = 1'b1;
        repeat (3) nxt();

        // reset values
        do_reset();
        @(negedge clk);
        chk("reset_r", r, 25);
        chk("reset_busy", busy, 0);
        chk("reset_at_min", at_min, 0);
        chk("reset_at_max", at_max, 0);
        chk("reset_r_init52", r2, 52);
        nxt();

        // single grow, table-driven
        do_reset();
        for (int i = 0; i < 14; i++)
            for (int j = 0; j < tv[i].n; j++) begin
                tick = tv[i].tk;
                eat_evt = tv[i].eat;
                @(negedge clk);
                chk($sformatf("grow_r[%0d.%0d]", i, j), r, tv[i].exp_r);
                chk($sformatf("grow_busy[%0d.%0d]", i, j), busy, tv[i].exp_busy);
                nxt();
            end
        clr_in();

        // clamp at R_MAX on the R_INIT=52 instance
        do_reset();
        tick = 1'b1;
        btn_plus = 1'b1;
        repeat (3) nxt();
        btn_plus = 1'b0;
        repeat (5) nxt();
        @(negedge clk);
        chk("clamp_r", r2, 55);
        chk("clamp_busy", busy2, 0);
        chk("clamp_at_max", at_max2, 1);
        nxt();
        btn_plus = 1'b1;
        busy_seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) btn_plus = 1'b0;
            @(negedge clk);
            if (busy2) busy_seen++;
            nxt();
        end
        chk("clamp_silent_busy", busy_seen, 0);
        chk("clamp_silent_r", r2, 55);
        btn_minus = 1'b1;
        nxt();
        nxt();
        btn_minus = 1'b0;
        repeat (10) nxt();
        @(negedge clk);
        chk("clamp_then_minus_r", r2, 50);
        chk("clamp_then_minus_at_max", at_max2, 0);
        nxt();

        // eat and decay together: grow first, then shrink
        do_reset();
        tick = 1'b1;
        eat_evt = 1'b1;
        decay_evt = 1'b1;
        periods = 0; maxr = 0; pb = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (busy && !pb) periods++;
            pb = busy;
            if (r > maxr) maxr = r;
            if (c == 7) chk("simul_mid", int'(r) * 2 + int'(busy), 60);
            nxt();
            eat_evt = 1'b0;
            decay_evt = 1'b0;
        end
        chk("simul_periods", periods, 2);
        chk("simul_max", maxr, 30);
        chk("simul_final", r, 25);

        // held minus auto-repeats at edge, +8, +16
        do_reset();
        tick = 1'b1;
        btn_minus = 1'b1;
        periods = 0; pb = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 20) btn_minus = 1'b0;
            @(negedge clk);
            if (busy && !pb) periods++;
            pb = busy;
            nxt();
        end
        chk("repeat_periods", periods, 3);
        chk("repeat_r", r, 10);
        btn_plus = 1'b1;
        btn_minus = 1'b1;
        busy_seen = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 20) begin btn_plus = 1'b0; btn_minus = 1'b0; end
            @(negedge clk);
            if (busy) busy_seen++;
            nxt();
        end
        chk("both_busy", busy_seen, 0);
        chk("both_r", r, 10);

        // asynchronous reset in the middle of a ramp
        do_reset();
        tick = 1'b1;
        eat_evt = 1'b1;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (r == 28 && busy) hit = 1;
            else begin nxt(); eat_evt = 1'b0; end
        end
        chk("midramp_reached", hit, 1);
        rst_n = 1'b0;
        #1;
        chk("midramp_async_r", r, 25);
        chk("midramp_async_busy", busy, 0);
        nxt();
        rst_n = 1'b1;
        busy_seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            nxt();
        end
        chk("midramp_no_resume", busy_seen, 0);
        chk("midramp_r", r, 25);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            tick = ($urandom % 2) == 1;
            eat_evt = ($urandom % 12) == 0;
            decay_evt = ($urandom % 10) == 0;
            if (($urandom % 16) == 0) btn_plus = ~btn_plus;
            if (($urandom % 16) == 0) btn_minus = ~btn_minus;
            @(negedge clk);
            act = int'(r) * 8 + (busy ? 4 : 0) + (at_max ? 2 : 0) + (at_min ? 1 : 0);
            exp = m_r * 8 + (m_ramp ? 4 : 0) + (m_r == 55 ? 2 : 0) + (m_r == 5 ? 1 : 0);
            chk($sformatf("rand[%0d] r*8+busy*4+max*2+min", c), act, exp);
            model_step();
            nxt();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
